// File: rtl/uart_tx_pattern_gen.sv
// Periodic burst sequencer feeding uart_byte_tx over the Send_Go/Tx_done handshake.
// Define UART_TX_CKSUM_EN to append a mod-256 sum byte to each complete burst.
//
// Ports:
//   Clk, Reset_n        clock, async active-low reset
//   Enable              level, 1 = generate bursts
//   Mode[1:0]           0 incr, 1 fixed, 2 LFSR, 3 walking-one
//   Seed[7:0]           pattern load / fixed value
//   Tx_done             end-of-byte pulse from uart_byte_tx
//   Send_Go             start pulse to uart_byte_tx
//   Data[7:0]           byte to send, held until Tx_done
//   Busy                burst in progress
//   Burst_done          pulse after the burst's final Tx_done
//   Overrun             sticky, a period tick hit a busy burst
module uart_tx_pattern_gen #(
  parameter int PERIOD_CYCLES = 500000,
  parameter int BURST_LEN     = 1,
  parameter int CNT_W         = 19
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Enable,
  input  logic [1:0] Mode,
  input  logic [7:0] Seed,
  input  logic       Tx_done,
  output logic       Send_Go,
  output logic [7:0] Data,
  output logic       Busy,
  output logic       Burst_done,
  output logic       Overrun
);

`ifdef UART_TX_CKSUM_EN
  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_DONE, CKSUM, CKSUM_WAIT
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, SEND, WAIT_DONE
  } state_t;
`endif

  localparam logic [CNT_W-1:0] PMAX =
    CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [7:0] BLEN = 8'(BURST_LEN);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q;
  logic             en_q;
  logic             tick;
  logic             en_rise;
  logic             start;
  logic [7:0]       pat_q, pat_n;
  logic [7:0]       data_q, data_n;
  logic [7:0]       bcnt_q, bcnt_n;
  logic [7:0]       seed_ld;
  logic [1:0]       mode_q;
  logic             busy_q;
  logic             done_q, done_n;
  logic             ovr_q;
  logic             sg_q;
`ifdef UART_TX_CKSUM_EN
  logic [7:0]       sum_q, sum_n;
`endif

  function automatic logic [7:0] advance(
    input logic [7:0] p,
    input logic [1:0] m
  );
    logic [7:0] r;
    r = p;
    unique case (1'b1)
      m == 2'd0: r = p + 8'd1;
      m == 2'd1: r = p;
      m == 2'd2: r = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
      m == 2'd3: r = {p[6:0], p[7]};
    endcase
    return r;
  endfunction

  assign tick    = Enable && (cnt_q == ONE);
  assign en_rise = Enable && !en_q;
  // An all-zero LFSR would lock up, so seed 0 becomes 01 there.
  assign seed_ld = (Mode == 2'd2 && Seed == 8'h00) ?
                   8'h01 : Seed;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (!Enable) begin
      cnt_q <= '0;
    end else if (cnt_q == PMAX) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + ONE;
    end
  end

  always_comb begin
    state_n = state_q;
    pat_n   = pat_q;
    data_n  = data_q;
    bcnt_n  = bcnt_q;
    done_n  = 1'b0;
    start   = 1'b0;
`ifdef UART_TX_CKSUM_EN
    sum_n   = sum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tick && !busy_q) begin
          start   = 1'b1;
          state_n = SEND;
          bcnt_n  = 8'd0;
          data_n  = pat_q;
`ifdef UART_TX_CKSUM_EN
          sum_n   = 8'd0;
`endif
        end
      end
      SEND: state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (Tx_done) begin
          bcnt_n = bcnt_q + 8'd1;
          pat_n  = advance(pat_q, mode_q);
`ifdef UART_TX_CKSUM_EN
          sum_n  = sum_q + data_q;
`endif
          if (bcnt_n == BLEN || !Enable) begin
`ifdef UART_TX_CKSUM_EN
            if (Enable) begin
              state_n = CKSUM;
              data_n  = sum_n;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
`else
            state_n = IDLE;
            done_n  = 1'b1;
`endif
          end else begin
            state_n = SEND;
            data_n  = pat_n;
          end
        end
      end
`ifdef UART_TX_CKSUM_EN
      CKSUM: state_n = CKSUM_WAIT;
      CKSUM_WAIT: begin
        if (Tx_done) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    if (en_rise) begin
      pat_n = seed_ld;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pat_q   <= 8'd0;
      data_q  <= 8'd0;
      bcnt_q  <= 8'd0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      mode_q  <= 2'd0;
    end else begin
      state_q <= state_n;
      pat_q   <= pat_n;
      data_q  <= data_n;
      bcnt_q  <= bcnt_n;
      done_q  <= done_n;
      en_q    <= Enable;
      if (en_rise || start) begin
        mode_q <= Mode;
      end
    end
  end

`ifdef UART_TX_CKSUM_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sum_q <= 8'd0;
    end else begin
      sum_q <= sum_n;
    end
  end
`endif

  // Busy is held through the Burst_done cycle so both drop together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
      sg_q   <= 1'b0;
    end else begin
      if (start) begin
        busy_q <= 1'b1;
      end else if (done_q) begin
        busy_q <= 1'b0;
      end
      if (en_rise) begin
        ovr_q <= 1'b0;
      end else if (tick && busy_q) begin
        ovr_q <= 1'b1;
      end
`ifdef UART_TX_CKSUM_EN
      sg_q <= (state_q == SEND) || (state_q == CKSUM);
`else
      sg_q <= (state_q == SEND);
`endif
    end
  end

  assign Send_Go    = sg_q;
  assign Data       = data_q;
  assign Busy       = busy_q;
  assign Burst_done = done_q;
  assign Overrun    = ovr_q;

endmodule

// File: tb/tb_uart_tx_pattern_gen.sv
// Scoreboard bench for uart_tx_pattern_gen.
// Expected bytes queued by stimulus, checked by a Send_Go monitor.
module tb_uart_tx_pattern_gen;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Enable;
  logic [1:0] Mode;
  logic [7:0] Seed;
  logic       Tx_done;
  logic       Send_Go;
  logic [7:0] Data;
  logic       Busy;
  logic       Burst_done;
  logic       Overrun;

  int         vectors = 0;
  int         miscompares = 0;
  int         bd_cnt = 0;
  int         sg_cnt = 0;
  int         dly = 20;
  logic [7:0] exp_q[$];
  logic [7:0] cur_exp = 8'h00;

  uart_tx_pattern_gen #(
    .PERIOD_CYCLES(200),
    .BURST_LEN(3),
    .CNT_W(8)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .Enable(Enable),
    .Mode(Mode),
    .Seed(Seed),
    .Tx_done(Tx_done),
    .Send_Go(Send_Go),
    .Data(Data),
    .Busy(Busy),
    .Burst_done(Burst_done),
    .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push3(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
`ifdef UART_TX_CKSUM_EN
    exp_q.push_back(a + b + c);
`endif
  endtask

  task automatic wait_bd(input string name, input int budget);
    int s;
    bit seen;
    s = bd_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (bd_cnt != s) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Byte transmitter model
  initial begin
    Tx_done = 1'b0;
    forever begin
      @(negedge Clk);
      if (Send_Go === 1'b1) begin
        repeat (dly) @(negedge Clk);
        Tx_done = 1'b1;
        @(negedge Clk);
        Tx_done = 1'b0;
      end
    end
  end

  // Monitor
  always @(negedge Clk) begin
    #1;
    if (Reset_n === 1'b1) begin
      if (Send_Go === 1'b1) begin
        sg_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_send_go", 32'd1, 32'd0);
        end else begin
          cur_exp = exp_q.pop_front();
          chk("send_data", {24'd0, Data}, {24'd0, cur_exp});
        end
      end
      if (Tx_done === 1'b1) begin
        chk("data_hold", {24'd0, Data}, {24'd0, cur_exp});
      end
      if (Burst_done === 1'b1) begin
        bd_cnt++;
      end
    end
  end

  initial begin
    int b0;
    int s0;
    Reset_n = 1'b0;
    Enable  = 1'b0;
    Mode    = 2'd0;
    Seed    = 8'h00;
    cyc(3);
    chk("reset_outs",
        {27'd0, Send_Go, Busy, Burst_done, Overrun, 1'b0},
        32'd0);
    chk("reset_data", {24'd0, Data}, 32'd0);
    Reset_n = 1'b1;
    cyc(3);

    // incrementing, two periods
    push3(8'h00, 8'h01, 8'h02);
    push3(8'h03, 8'h04, 8'h05);
    b0 = bd_cnt;
    Enable = 1'b1;
    cyc(390);
    Enable = 1'b0;
    chk("t1_bursts", bd_cnt - b0, 2);
    chk("t1_overrun", {31'd0, Overrun}, 0);
    cyc(10);
    chk("t1_busy", {31'd0, Busy}, 0);

    // fixed
    Mode = 2'd1;
    Seed = 8'hA5;
    push3(8'hA5, 8'hA5, 8'hA5);
    Enable = 1'b1;
    wait_bd("t2_done", 300);
    Enable = 1'b0;
    chk("t2_overrun", {31'd0, Overrun}, 0);
    cyc(10);

    // LFSR, seed 0 loads 01
    Mode = 2'd2;
    Seed = 8'h00;
    push3(8'h01, 8'h02, 8'h04);
    push3(8'h08, 8'h11, 8'h23);
    Enable = 1'b1;
    wait_bd("t3_lfsr_b1", 300);
    wait_bd("t3_lfsr_b2", 300);
    Enable = 1'b0;
    cyc(10);

    // walking one
    Mode = 2'd3;
    Seed = 8'h40;
    push3(8'h40, 8'h80, 8'h01);
    Enable = 1'b1;
    wait_bd("t3_walk", 300);
    Enable = 1'b0;
    cyc(10);

    // slow transmitter forces overrun
    dly  = 90;
    Mode = 2'd1;
    Seed = 8'h5A;
    push3(8'h5A, 8'h5A, 8'h5A);
    Enable = 1'b1;
    wait_bd("t4_done", 600);
    chk("t4_overrun_set", {31'd0, Overrun}, 1);
    cyc(2);
    chk("t4_busy_low", {31'd0, Busy}, 0);
    Enable = 1'b0;
    cyc(3);
    chk("t4_overrun_sticky", {31'd0, Overrun}, 1);
    dly = 20;
    push3(8'h5A, 8'h5A, 8'h5A);
    Enable = 1'b1;
    cyc(2);
    chk("t4_overrun_clr", {31'd0, Overrun}, 0);
    wait_bd("t4_done2", 300);
    Enable = 1'b0;
    chk("t4_overrun_stays0", {31'd0, Overrun}, 0);
    cyc(10);

    // drop Enable during byte 2
    Mode = 2'd0;
    Seed = 8'h10;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    s0 = sg_cnt;
    b0 = bd_cnt;
    Enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (sg_cnt - s0 >= 2) break;
    end
    chk("t5_second_go", sg_cnt - s0, 2);
    cyc(5);
    Enable = 1'b0;
    wait_bd("t5_done", 100);
    cyc(60);
    chk("t5_no_third", sg_cnt - s0, 2);
    chk("t5_one_burst", bd_cnt - b0, 1);
    chk("t5_busy", {31'd0, Busy}, 0);

    // reset during WAIT_DONE
    Mode = 2'd1;
    Seed = 8'h3C;
    exp_q.push_back(8'h3C);
    s0 = sg_cnt;
    Enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (sg_cnt != s0) break;
    end
    cyc(5);
    chk("t6_busy_before", {31'd0, Busy}, 1);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("t6_outs_reset",
        {23'd0, Send_Go, Data, Busy, Burst_done, Overrun},
        32'd0);
    Enable = 1'b0;
    cyc(30);
    Reset_n = 1'b1;
    cyc(3);
    chk("t6_outs_after",
        {23'd0, Send_Go, Data, Busy, Burst_done, Overrun},
        32'd0);

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
